// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush controller for the 5-stage pipeline. It drives the
//   enable and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
//   registers and the PC write enable. It resolves three situations:
//   load-use hazards, taken-branch flushes resolved in EX, and the
//   multi-cycle occupancy of EX by mult/div. A saturating counter records
//   how many cycles the PC was frozen.
//
// Parameters
//   MULT_CYCLES  total EX cycles a multiply occupies (>=2)
//   DIV_CYCLES   total EX cycles a divide occupies (>=2)
//   CNT_W        width of the stall_cycles counter
//
// Ports
//   Clk            pipeline clock, rising edge
//   Rst_n          asynchronous reset, active-low
//   id_rs, id_rt   source registers of the instruction in ID
//   id_use_rs/rt   ID instruction actually reads rs / rt
//   ex_memread     instruction in EX is a load
//   ex_rd          destination register of the instruction in EX
//   ex_branch_tk   branch/jump in EX resolved taken
//   ex_md_start    instruction in EX is mult/div
//   ex_md_op       0 = mult, 1 = div
//   pc_en          PC write enable
//   ifid_en/flush  IF/ID enable / clear
//   idex_en/flush  ID/EX enable / clear
//   exmem_en/flush EX/MEM enable / clear
//   memwb_en       MEM/WB enable
//   md_busy        mult/div sequencer is in BUSY
//   md_done        one-cycle pulse on the last mult/div cycle
//   stall_cycles   number of cycles with pc_en low, saturating
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 16,
  parameter int CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_tk,
  input  logic             ex_md_start,
  input  logic             ex_md_op,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int MD_W       = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_reg, state_next;
  logic [MD_W-1:0]   md_cnt_reg, md_cnt_next;
  logic [CNT_W-1:0]  stall_cycles_reg;
  logic              md_stall;
  logic              md_last;
  logic              load_use;

  // The counter is preloaded with N-2 so that the start cycle plus N-2
  // counting cycles give N-1 frozen cycles, and the zero cycle is the done cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg  <= IDLE;
      md_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      md_cnt_reg <= md_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    md_cnt_next = md_cnt_reg;
    md_stall    = 1'b0;
    md_last     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ex_md_start) begin
          state_next  = BUSY;
          md_cnt_next = ex_md_op ? MD_W'(DIV_CYCLES - 2) : MD_W'(MULT_CYCLES - 2);
          md_stall    = 1'b1;
        end
      end
      BUSY: begin
        if (md_cnt_reg != '0) begin
          md_cnt_next = md_cnt_reg - 1'b1;
          md_stall    = 1'b1;
        end else begin
          md_last    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  // Pipeline control. While reset is held every register is cleared.
  // A taken branch beats load-use because the ID instruction is squashed anyway.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    if (!Rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_en     = 1'b0;
      idex_flush  = 1'b1;
      exmem_en    = 1'b0;
      exmem_flush = 1'b1;
      memwb_en    = 1'b0;
    end else if (md_stall) begin
      // Hold IF/ID/EX in place and feed a bubble into MEM.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end else if (ex_branch_tk) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign md_busy = Rst_n && (state_reg == BUSY);
  assign md_done = Rst_n && md_last;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cycles_reg <= '0;
    end else if (!pc_en && (stall_cycles_reg != {CNT_W{1'b1}})) begin
      stall_cycles_reg <= stall_cycles_reg + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl with directed corner cases.
// Two instances share stimulus: the default one (CNT_W=32) and a narrow
// one (CNT_W=3) whose stall counter saturates at 7.
module tb_pipe_hazard_ctrl;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 16;

  logic        Clk;
  logic        Rst_n;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rs, id_use_rt, ex_memread, ex_branch_tk, ex_md_start, ex_md_op;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en, md_busy, md_done;
  logic [31:0] stall_cycles;

  logic        pc_en3, ifid_en3, ifid_flush3, idex_en3, idex_flush3;
  logic        exmem_en3, exmem_flush3, memwb_en3, md_busy3, md_done3;
  logic [2:0]  stall_cycles3;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state
  int     md_left;    // EX cycles still owed by a mult/div after its start cycle
  longint stall_ref;  // unbounded count of pc_en-low cycles

  pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(32)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_branch_tk(ex_branch_tk), .ex_md_start(ex_md_start),
    .ex_md_op(ex_md_op), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .md_busy(md_busy),
    .md_done(md_done), .stall_cycles(stall_cycles)
  );

  pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(3)) u_dut3 (
    .Clk(Clk), .Rst_n(Rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_branch_tk(ex_branch_tk), .ex_md_start(ex_md_start),
    .ex_md_op(ex_md_op), .pc_en(pc_en3), .ifid_en(ifid_en3), .ifid_flush(ifid_flush3),
    .idex_en(idex_en3), .idex_flush(idex_flush3), .exmem_en(exmem_en3),
    .exmem_flush(exmem_flush3), .memwb_en(memwb_en3), .md_busy(md_busy3),
    .md_done(md_done3), .stall_cycles(stall_cycles3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // A taken branch never shares EX with a mult/div start.
  always @(posedge Clk) begin
    if (Rst_n) begin
      assert (!(ex_branch_tk && ex_md_start))
        else $display("FAIL illegal_br_md: branch and md_start together");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] pack_ctl(input logic p, ie, ifl, de, dfl, ee, efl, we, b, d);
    return {p, ie, ifl, de, dfl, ee, efl, we, b, d};
  endfunction

  // Expected control word from the behavioural rules.
  function automatic logic [9:0] model_ctl();
    logic p, ie, ifl, de, dfl, ee, efl, we, b, d;
    bit   stall, lu;
    if (!Rst_n) return pack_ctl(0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    stall = (md_left == 0 && ex_md_start) || (md_left > 1);
    d     = (md_left == 1);
    b     = (md_left > 0);
    lu    = ex_memread && ex_rd != 0 &&
            ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    p = 1; ie = 1; ifl = 0; de = 1; dfl = 0; ee = 1; efl = 0; we = 1;
    if (stall) begin
      p = 0; ie = 0; de = 0; efl = 1;
    end else if (ex_branch_tk) begin
      ifl = 1; dfl = 1;
    end else if (lu) begin
      p = 0; ie = 0; dfl = 1;
    end
    return pack_ctl(p, ie, ifl, de, dfl, ee, efl, we, b, d);
  endfunction

  function automatic logic [9:0] obs_ctl();
    return pack_ctl(pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                    exmem_en, exmem_flush, memwb_en, md_busy, md_done);
  endfunction

  function automatic logic [9:0] obs_ctl3();
    return pack_ctl(pc_en3, ifid_en3, ifid_flush3, idex_en3, idex_flush3,
                    exmem_en3, exmem_flush3, memwb_en3, md_busy3, md_done3);
  endfunction

  task automatic check_all(input string tag);
    logic [9:0]  e;
    logic [31:0] e32, e3;
    e   = model_ctl();
    e32 = (stall_ref > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(stall_ref);
    e3  = (stall_ref > 7) ? 32'd7 : 32'(stall_ref);
    chk({tag, "_ctl"}, {22'd0, obs_ctl()}, {22'd0, e});
    chk({tag, "_ctl3"}, {22'd0, obs_ctl3()}, {22'd0, e});
    chk({tag, "_cnt"}, stall_cycles, e32);
    chk({tag, "_cnt3"}, {29'd0, stall_cycles3}, e3);
  endtask

  task automatic set_in(input logic [4:0] rs, rt, input logic urs, urt, mr,
                        input logic [4:0] rd, input logic br, ms, op);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_memread = mr; ex_rd = rd; ex_branch_tk = br; ex_md_start = ms; ex_md_op = op;
  endtask

  // Called just after a falling edge with inputs already driven: check,
  // cross the rising edge, advance the model, return at the next falling edge.
  task automatic apply(input string tag);
    bit pc_low;
    #1;
    check_all(tag);
    pc_low = !model_ctl()[9];
    @(posedge Clk);
    if (Rst_n) begin
      if (pc_low) stall_ref++;
      if (md_left == 0) begin
        if (ex_md_start) md_left = (ex_md_op ? DIV_N : MULT_N) - 1;
      end else begin
        md_left--;
      end
    end
    @(negedge Clk);
    $display("vec %-10s rs=%0d rt=%0d mr=%0b rd=%0d br=%0b ms=%0b op=%0b pc_en=%0b md_busy=%0b stall=%0d",
             tag, id_rs, id_rt, ex_memread, ex_rd, ex_branch_tk, ex_md_start, ex_md_op,
             pc_en, md_busy, stall_cycles);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    md_left = 0;
    stall_ref = 0;
    #1;
    check_all("reset");
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    Rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    md_left = 0;
    stall_ref = 0;
    @(negedge Clk);
    do_reset();

    // idle after release
    apply("idle");

    // single load-use cycle, then the same with rd=0
    set_in(5, 1, 1, 0, 1, 5, 0, 0, 0); apply("lu_rs");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); apply("lu_after");
    set_in(0, 0, 1, 1, 1, 0, 0, 0, 0); apply("lu_rd0");
    set_in(3, 9, 0, 1, 1, 9, 0, 0, 0); apply("lu_rt");
    set_in(9, 9, 0, 0, 1, 9, 0, 0, 0); apply("lu_nouse");

    // multiply, then divide
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); apply("mul_start");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < MULT_N; i++) apply("mul_run");
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); apply("div_start");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DIV_N; i++) apply("div_run");

    // branch beats load-use; branch ignored during md stall
    set_in(7, 7, 1, 1, 1, 7, 1, 0, 0); apply("br_lu");
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); apply("mul_start2");
    set_in(7, 7, 1, 1, 1, 7, 1, 0, 0); apply("br_in_md");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply("mul_run2");

    // reset in the third cycle of a divide
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); apply("div_start2");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); apply("div_c2");
    #1;
    check_all("div_c3");
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) apply("post_rst");

    // narrow counter saturation
    do_reset();
    set_in(4, 0, 1, 0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 9; i++) apply("sat_lu");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); apply("sat_idle");
    chk("sat7", {29'd0, stall_cycles3}, 32'd7);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic ms, br;
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        ms = ($urandom_range(0, 99) < 8);
        br = ms ? 1'b0 : ($urandom_range(0, 99) < 20);
        set_in(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom_range(0, 7)), br, ms, 1'($urandom));
        apply("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
